baseline_dac_servo: RTL and testbench
=====================================

Name: baseline_dac_servo

Overview:
- Calibration initiator that drives the ADC front-end offset DAC and the baseline measurement block.
- Runs an MSB-first successive-approximation search over the DAC code. For each trial it writes the DAC, waits for settling, issues a dacset pulse and waits for a fresh baseline.
- Returns the largest code whose measured baseline is at or below a programmed target (the inverse when POL=1).
- Sits between the run-control registers and the DAC serial writer and the baseline measurement block on each ADC channel.

Parameters:
- DAC_W, 12, DAC code width (search steps = DAC_W).
- SETTLE_CYC, 256, clk cycles to wait after the DAC write completes before arming a measurement.
- DACSET_LEN, 4, dacset high time in cycles (must be ≥2; the measurer needs a sampled falling edge).
- TIMEOUT, 65535, max cycles waiting for each phase of meas_done before aborting.
- POL, 0, 0: baseline rises with DAC code; 1: baseline falls with DAC code.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins calibration when idle
- target  in  14  desired baseline (ADC counts, unsigned); sampled at start
- dac_code  out  DAC_W  code presented to the DAC writer
- dac_wr  out  1  one-cycle write strobe to the DAC writer
- dac_busy  in  1  DAC writer busy; high from the cycle after dac_wr until the write completes
- dacset  out  1  measurement trigger to the baseline block
- meas_done  in  1  baseline block done flag (level)
- baseline  in  14  baseline block result
- busy  out  1  calibration in progress
- cal_done  out  1  one-cycle pulse at successful completion
- cal_err  out  1  sticky timeout flag; cleared by the next accepted start or by rst
- result_code  out  DAC_W  final DAC code
- result_baseline  out  14  baseline measured at result_code

Behaviour:
- Reset values:
  - Every output is 0.
  - State is IDLE, and the internal trial code and bit index are cleared.
  - rst has priority over all events, including mid-search. It drops dacset and busy on the next edge.
  - A DAC write already in flight is not cancelled.
- States: IDLE, WR, WRWAIT, SETTLE, ARM, DISARM, MEAS, DECIDE, FINAL, DONE.
- IDLE:
  - start latches target.
  - acc is the accepted-code register (DAC_W bits). It is set to 0, and the bit index is set to DAC_W-1.
  - cal_err is cleared, busy is set, and the FSM goes to WR.
  - start in any other state is ignored.
- WR:
  - dac_code = acc | (1<<idx) during the search; dac_code = acc in the final pass.
  - dac_wr is asserted for exactly one cycle, then the FSM goes to WRWAIT.
- WRWAIT:
  - Waits one cycle, then waits for dac_busy=0.
  - The timeout counter runs; on expiry the FSM goes to the abort path.
- SETTLE: counts SETTLE_CYC cycles (count 0..SETTLE_CYC-1), then goes to ARM.
- ARM: dacset is high for DACSET_LEN consecutive cycles, then drops, and the FSM goes to DISARM.
- DISARM:
  - Waits for meas_done=0. This discards the stale done from the previous measurement.
  - Timeout applies.
- MEAS:
  - Waits for meas_done=1, then captures baseline in the same cycle.
  - Timeout applies.
- DECIDE (search pass):
  - keep = (POL==0) ? (baseline <= target) : (baseline >= target).
  - The comparison is 14-bit unsigned.
  - If keep, acc[idx] is set.
  - If idx==0, the FSM goes to FINAL; otherwise idx decrements and the FSM goes to WR.
- FINAL:
  - Runs one more WR, WRWAIT, SETTLE, ARM, DISARM, MEAS pass with dac_code=acc.
  - At MEAS capture: result_code=acc, result_baseline=baseline, then the FSM goes to DONE.
- DONE: cal_done is pulsed for one cycle, busy drops, and the FSM returns to IDLE.
- Totals: DAC_W+1 measurements and DAC_W+1 dac_wr strobes per calibration.
- Abort path (any timeout):
  - cal_err is set and busy drops.
  - dacset goes low, and dac_code holds its last value.
  - result_* is unchanged and there is no cal_done pulse; the FSM returns to IDLE.
- Timeout counter: reloaded on every state entry; abort when it reaches TIMEOUT.
- dac_code holds its value outside WR; it is never changed while dac_busy=1.
- Boundary cases:
  - If no trial is kept, acc=0.
  - If all trials are kept, acc = all ones.
  - target=0 with POL=0 is legal; it keeps a bit only when baseline==0.
- Capture uses the first cycle meas_done=1; later high cycles are ignored.

Test Plan:
- Model: baseline = 1000 + 2*dac_code, DAC writer busy 20 cycles, measurer done 300 cycles after the dacset falling edge. Nominal run: target=5000, POL=0 -> result_code=2000, result_baseline=5000, 13 dac_wr strobes, cal_done pulse, cal_err=0.
- target=500 -> result_code=0, result_baseline=1000. target=16383 -> result_code=4095, result_baseline=9190.
- POL=1 with model baseline = 9190 - 2*code, target=5000 -> result_code=2095, result_baseline=5000.
- meas_done stuck high (never falls) -> cal_err=1 after TIMEOUT in DISARM, busy=0, no cal_done. A following start clears cal_err and completes normally.
- start pulsed mid-search -> ignored, single cal_done. rst asserted during SETTLE -> next cycle all outputs 0, state IDLE. A fresh start then yields result_code=2000.
- dacset checks: dacset high exactly DACSET_LEN=4 cycles each trial, never asserted while dac_busy=1 or during SETTLE. dac_code stable whenever dac_busy=1.

Source files
------------

// File: rtl/baseline_dac_servo.sv
// Successive-approximation offset DAC servo: searches the DAC code MSB-first so the
// measured baseline lands at or below (POL=0) / at or above (POL=1) a programmed target.
module baseline_dac_servo #(
    parameter int DAC_W      = 12,
    parameter int SETTLE_CYC = 256,
    parameter int DACSET_LEN = 4,
    parameter int TIMEOUT    = 65535,
    parameter bit POL        = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [13:0]      target,
    output logic [DAC_W-1:0] dac_code,
    output logic             dac_wr,
    input  logic             dac_busy,
    output logic             dacset,
    input  logic             meas_done,
    input  logic [13:0]      baseline,
    output logic             busy,
    output logic             cal_done,
    output logic             cal_err,
    output logic [DAC_W-1:0] result_code,
    output logic [13:0]      result_baseline
);

    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYC)
                           ? ((TIMEOUT > DACSET_LEN) ? TIMEOUT : DACSET_LEN)
                           : ((SETTLE_CYC > DACSET_LEN) ? SETTLE_CYC : DACSET_LEN);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int IDX_W = (DAC_W > 1) ? $clog2(DAC_W) : 1;

    typedef enum logic [3:0] {
        IDLE, WR, WRWAIT, SETTLE, ARM, DISARM, MEAS, DECIDE, FINAL, DONE
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [DAC_W-1:0]   acc;
    logic [DAC_W-1:0]   code_q;
    logic [IDX_W-1:0]   idx;
    logic [13:0]        tgt;
    logic [13:0]        meas_val;
    logic               final_pass;
    logic               abort;
    logic               timed_out;
    logic               keep;
    logic [DAC_W-1:0]   trial;

    assign timed_out = (cnt == CNT_W'(TIMEOUT));
    assign trial     = final_pass ? acc : (acc | (DAC_W'(1) << idx));
    assign keep      = POL ? (meas_val >= tgt) : (meas_val <= tgt);

    // dac_code follows the trial only during the write strobe and holds otherwise,
    // so it cannot move while the writer is busy.
    assign dac_code  = (state == WR) ? trial : code_q;
    assign dac_wr    = (state == WR);
    assign dacset    = (state == ARM);
    assign busy      = (state != IDLE);
    assign cal_done  = (state == DONE);

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        next_state = state;
        abort      = 1'b0;
        case (state)
            IDLE:    if (start) next_state = WR;
            WR:      next_state = WRWAIT;
            // First WRWAIT cycle is skipped: the writer raises busy one cycle after dac_wr.
            WRWAIT:  if (cnt != '0 && !dac_busy) next_state = SETTLE;
                     else if (timed_out)        abort = 1'b1;
            SETTLE:  if (cnt == CNT_W'(SETTLE_CYC - 1)) next_state = ARM;
            ARM:     if (cnt == CNT_W'(DACSET_LEN - 1)) next_state = DISARM;
            DISARM:  if (!meas_done)     next_state = MEAS;
                     else if (timed_out) abort = 1'b1;
            MEAS:    if (meas_done)      next_state = final_pass ? DONE : DECIDE;
                     else if (timed_out) abort = 1'b1;
            DECIDE:  next_state = (idx == '0) ? FINAL : WR;
            FINAL:   next_state = WR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // sees pre-edge values regardless of statement order.
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            code_q          <= '0;
            idx             <= '0;
            tgt             <= '0;
            meas_val        <= '0;
            final_pass      <= 1'b0;
            cal_err         <= 1'b0;
            result_code     <= '0;
            result_baseline <= '0;
        end else begin
            state <= next_state;
            // Phase counter restarts on every state entry; idle never counts.
            if (next_state != state || state == IDLE) cnt <= '0;
            else                                      cnt <= cnt + CNT_W'(1);

            case (state)
                IDLE: if (start) begin
                    tgt        <= target;
                    acc        <= '0;
                    idx        <= IDX_W'(DAC_W - 1);
                    final_pass <= 1'b0;
                    cal_err    <= 1'b0;
                end
                WR:   code_q <= trial;
                MEAS: if (meas_done) begin
                    meas_val <= baseline;
                    if (final_pass) begin
                        result_code     <= acc;
                        result_baseline <= baseline;
                    end
                end
                DECIDE: begin
                    if (keep) acc[idx] <= 1'b1;
                    if (idx != '0) idx <= idx - IDX_W'(1);
                end
                FINAL: final_pass <= 1'b1;
                default: ;
            endcase

            if (abort) cal_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_baseline_dac_servo.sv
// Bench for baseline_dac_servo: two instances (POL=0 and POL=1) share control inputs,
// each with its own DAC-writer / linear baseline-measurer environment.
module tb_baseline_dac_servo;

    localparam int DAC_W      = 12;
    localparam int SETTLE_CYC = 256;
    localparam int DACSET_LEN = 4;
    localparam int TMO        = 2000;
    localparam int WR_BUSY    = 20;
    localparam int MEAS_LAT   = 300;
    localparam int RUN_BUDGET = 12000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [13:0]      target = '0;
    logic             stuck = 1'b0;

    logic [DAC_W-1:0] dac_code [2];
    logic             dac_wr [2];
    logic             dacset [2];
    logic             busy [2];
    logic             cal_done [2];
    logic             cal_err [2];
    logic [DAC_W-1:0] result_code [2];
    logic [13:0]      result_baseline [2];

    logic             dac_busy [2] = '{1'b0, 1'b0};
    logic             meas_done [2] = '{1'b0, 1'b0};
    logic [13:0]      baseline [2] = '{14'd0, 14'd0};

    int checks = 0;
    int errors = 0;
    int wr_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int exp_code [2] = '{0, 0};
    int exp_base [2] = '{0, 0};

    always #5 clk = ~clk;

    baseline_dac_servo #(.DAC_W(DAC_W), .SETTLE_CYC(SETTLE_CYC), .DACSET_LEN(DACSET_LEN),
                         .TIMEOUT(TMO), .POL(1'b0)) u_pos (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .dac_code(dac_code[0]), .dac_wr(dac_wr[0]), .dac_busy(dac_busy[0]),
        .dacset(dacset[0]), .meas_done(meas_done[0]), .baseline(baseline[0]),
        .busy(busy[0]), .cal_done(cal_done[0]), .cal_err(cal_err[0]),
        .result_code(result_code[0]), .result_baseline(result_baseline[0])
    );

    baseline_dac_servo #(.DAC_W(DAC_W), .SETTLE_CYC(SETTLE_CYC), .DACSET_LEN(DACSET_LEN),
                         .TIMEOUT(TMO), .POL(1'b1)) u_neg (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .dac_code(dac_code[1]), .dac_wr(dac_wr[1]), .dac_busy(dac_busy[1]),
        .dacset(dacset[1]), .meas_done(meas_done[1]), .baseline(baseline[1]),
        .busy(busy[1]), .cal_done(cal_done[1]), .cal_err(cal_err[1]),
        .result_code(result_code[1]), .result_baseline(result_baseline[1])
    );

    // Analog transfer: instance 0 rises with code, instance 1 falls with code.
    function automatic int meas_fn(input int inst, input int code);
        return (inst == 1) ? (9190 - 2 * code) : (1000 + 2 * code);
    endfunction

    // Largest code meeting the target, found by the textbook SAR rule.
    function automatic void sar_model(input int inst, input int tgt, output int code, output int base);
        int acc = 0;
        for (int b = DAC_W - 1; b >= 0; b--) begin
            int t = acc | (1 << b);
            int v = meas_fn(inst, t);
            if ((inst == 1) ? (v >= tgt) : (v <= tgt)) acc = t;
        end
        code = acc;
        base = meas_fn(inst, acc);
    endfunction

    // Environment: DAC writer (busy WR_BUSY cycles) and baseline measurer
    // (done MEAS_LAT cycles after dacset falls, cleared while dacset is high).
    int          wcnt [2] = '{0, 0};
    int          ana [2] = '{0, 0};
    int          wcode [2] = '{0, 0};
    int          mcnt [2] = '{0, 0};
    logic        pend [2] = '{1'b0, 1'b0};
    logic        dacset_q [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dac_wr[i]) begin
                dac_busy[i] <= 1'b1;
                wcnt[i]     <= WR_BUSY;
                wcode[i]    <= int'(dac_code[i]);
            end else if (dac_busy[i]) begin
                if (wcnt[i] == 1) begin
                    dac_busy[i] <= 1'b0;
                    ana[i]      <= wcode[i];
                end
                wcnt[i] <= wcnt[i] - 1;
            end
            dacset_q[i] <= dacset[i];
            if (stuck) begin
                meas_done[i] <= 1'b1;
            end else if (dacset[i]) begin
                meas_done[i] <= 1'b0;
                pend[i]      <= 1'b0;
            end else if (dacset_q[i]) begin
                pend[i] <= 1'b1;
                mcnt[i] <= 1;
            end else if (pend[i]) begin
                if (mcnt[i] == MEAS_LAT - 1) begin
                    meas_done[i] <= 1'b1;
                    baseline[i]  <= 14'(meas_fn(i, ana[i]));
                    pend[i]      <= 1'b0;
                end
                mcnt[i] <= mcnt[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare process, sampled on the falling edge.
    task automatic monitor();
        int          hi_len [2];
        int          since_busy [2];
        logic [DAC_W-1:0] prev_code [2];
        logic        prev_dbusy [2];
        logic        prev_busy [2];
        for (int i = 0; i < 2; i++) begin
            hi_len[i] = 0; since_busy[i] = 0; prev_code[i] = '0;
            prev_dbusy[i] = 1'b0; prev_busy[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (busy[i] && !prev_busy[i]) wr_cnt[i] = 0;
                if (dac_wr[i]) wr_cnt[i]++;
                if (dac_busy[i] && prev_dbusy[i]) check("dac_code_stable", dac_code[i], prev_code[i]);
                if (dacset[i]) check("dacset_while_dac_busy", dac_busy[i], 1'b0);
                if (dacset[i] && hi_len[i] == 0)
                    check("settle_before_dacset", since_busy[i] >= SETTLE_CYC, 1'b1);
                if (dacset[i]) hi_len[i]++;
                else if (hi_len[i] != 0) begin
                    check("dacset_len", hi_len[i], DACSET_LEN);
                    hi_len[i] = 0;
                end
                since_busy[i] = dac_busy[i] ? 0 : since_busy[i] + 1;
                if (cal_done[i]) begin
                    done_cnt[i]++;
                    check("done_result_code", result_code[i], exp_code[i]);
                    check("done_result_baseline", result_baseline[i], exp_base[i]);
                    check("done_wr_strobes", wr_cnt[i], DAC_W + 1);
                    check("done_cal_err", cal_err[i], 1'b0);
                end
                prev_code[i]  = dac_code[i];
                prev_dbusy[i] = dac_busy[i];
                prev_busy[i]  = busy[i];
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_dac_code"}, dac_code[i], 0);
            check({tag, "_dac_wr"}, dac_wr[i], 0);
            check({tag, "_dacset"}, dacset[i], 0);
            check({tag, "_busy"}, busy[i], 0);
            check({tag, "_cal_done"}, cal_done[i], 0);
            check({tag, "_cal_err"}, cal_err[i], 0);
            check({tag, "_result_code"}, result_code[i], 0);
            check({tag, "_result_baseline"}, result_baseline[i], 0);
        end
    endtask

    // One calibration on both instances; c*/b* are hand-computed final result values.
    task automatic run_cal(input int tgt, input bit ok, input bit mid_start,
                           input int c0, input int b0, input int c1, input int b1);
        int d [2];
        int n;
        int mc, mb;
        for (int i = 0; i < 2; i++) begin
            sar_model(i, tgt, mc, mb);
            exp_code[i] = mc;
            exp_base[i] = mb;
            d[i] = done_cnt[i];
        end
        if (ok) begin
            check("model_code_pos", exp_code[0], c0);
            check("model_base_pos", exp_base[0], b0);
            check("model_code_neg", exp_code[1], c1);
            check("model_base_neg", exp_base[1], b1);
        end
        @(negedge clk);
        target = 14'(tgt);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy[0] && busy[1], 1'b1);
        check("cal_err_cleared_at_start", cal_err[0] || cal_err[1], 1'b0);
        if (mid_start) begin
            repeat (1000) @(negedge clk);
            target = 14'd500;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while ((busy[0] || busy[1]) && n < RUN_BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("run_terminates", n < RUN_BUDGET, 1'b1);
        repeat (2) @(negedge clk);
        check("done_pulses_pos", done_cnt[0] - d[0], ok ? 1 : 0);
        check("done_pulses_neg", done_cnt[1] - d[1], ok ? 1 : 0);
        check("cal_err_pos", cal_err[0], !ok);
        check("cal_err_neg", cal_err[1], !ok);
        check("final_busy", busy[0] || busy[1], 1'b0);
        check("result_code_pos", result_code[0], c0);
        check("result_baseline_pos", result_baseline[0], b0);
        check("result_code_neg", result_code[1], c1);
        check("result_baseline_neg", result_baseline[1], b1);
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_cal(5000,  1'b1, 1'b0, 2000, 5000, 2095, 5000);
        run_cal(500,   1'b1, 1'b0, 0,    1000, 4095, 1000);
        run_cal(16383, 1'b1, 1'b0, 4095, 9190, 0,    9190);

        stuck = 1'b1;
        run_cal(5000,  1'b0, 1'b0, 4095, 9190, 0,    9190);
        stuck = 1'b0;
        run_cal(5000,  1'b1, 1'b0, 2000, 5000, 2095, 5000);
        run_cal(5000,  1'b1, 1'b1, 2000, 5000, 2095, 5000);

        // Reset in the middle of SETTLE.
        @(negedge clk);
        target = 14'd5000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!dac_busy[0] && n < 100) begin @(negedge clk); n++; end
        check("reset_test_write_seen", n < 100, 1'b1);
        n = 0;
        while (dac_busy[0] && n < 100) begin @(negedge clk); n++; end
        check("reset_test_write_done", n < 100, 1'b1);
        repeat (10) @(negedge clk);
        check("busy_in_settle", busy[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", busy[0] || busy[1] || dac_wr[0] || dacset[0], 1'b0);
        run_cal(5000,  1'b1, 1'b0, 2000, 5000, 2095, 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
